uart_tx: RTL and testbench
==========================

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter DATA_W, default 8, number of data bits per frame.
REQ-002 Parameter CLKS_PER_BIT, default 4, clk cycles per serial bit; legal range 1..65535.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 data_in  input  DATA_W  parallel word to transmit.
REQ-006 valid  input  1  data_in holds a word to send.
REQ-007 ready  output  1  block can accept a word this cycle.
REQ-008 tx  output  1  serial line, idle high, registered.
REQ-009 busy  output  1  frame in progress, i.e. not IDLE.

Function
REQ-010 The frame SHALL be 1 start bit (0), then DATA_W data bits LSB first, then 1 stop bit (1).
REQ-011 Each bit SHALL hold tx for exactly CLKS_PER_BIT cycles; a frame SHALL last (DATA_W+2)*CLKS_PER_BIT cycles.
REQ-012 FSM states SHALL be IDLE, START, DATA, STOP.
- IDLE->START on valid&&ready.
- START->DATA after CLKS_PER_BIT cycles.
- DATA->STOP after DATA_W bits.
- STOP->IDLE after CLKS_PER_BIT cycles.
REQ-013 ready SHALL equal 1 only in IDLE; handshake occurs on a posedge with valid&&ready.
REQ-014 On handshake, data_in SHALL be captured into an internal shift register, and tx SHALL read 0 from the same edge onward (latency 0 cycles after accepting edge).
REQ-015 Changes on data_in or valid after the handshake SHALL NOT affect the frame in flight.
REQ-016 valid asserted while ready=0 SHALL be ignored and not queued.
REQ-017 After STOP completes, the FSM SHALL spend at least one cycle in IDLE with ready=1 and tx=1 before any next start bit; with valid held high, the next start bit SHALL begin exactly one cycle after STOP ends.
REQ-018 The bit-period counter SHALL be $clog2(CLKS_PER_BIT+1) bits wide, count 0..CLKS_PER_BIT-1, and wrap to 0 at each bit boundary.
REQ-019 The data-bit index SHALL be $clog2(DATA_W+1) bits wide; wrap beyond DATA_W-1 SHALL NOT occur.
REQ-020 With CLKS_PER_BIT=1, every bit SHALL last exactly one cycle with no dropped or duplicated bits.
REQ-021 busy SHALL equal ~ready at all times.

Reset
REQ-022 While rst_n=0, these SHALL hold immediately, independent of clk: state=IDLE, tx=1, ready=1, busy=0, counters=0, shift register=0.
REQ-023 Reset asserted mid-frame SHALL abort the frame; tx SHALL return to 1 without completing remaining bits.
REQ-024 The first handshake SHALL be possible on the first posedge after rst_n deasserts.

Structure
REQ-025 Package uart_pkg SHALL hold the FSM state encoding (2-bit localparams/typedef) and default CLKS_PER_BIT and DATA_W constants.
REQ-026 One sub-module baud_gen SHALL provide the bit-period counter and a one-cycle bit_done pulse; it SHALL be restarted by uart_tx at each handshake.
REQ-027 The shift register and FSM SHALL reside in uart_tx; tx SHALL be driven directly from a flop.

Verification
REQ-028 Send data_in=0xA5 with CLKS_PER_BIT=4 -> tx = 0,1,0,1,0,0,1,0,1,1, each held 4 cycles; 40 cycles total; ready=0 throughout, then ready=1.
REQ-029 Hold valid=1 with 0x00 then 0xFF -> two frames separated by exactly 1 idle cycle at tx=1; second frame data bits are all 1.
REQ-030 Change data_in from 0x3C to 0xC3 one cycle after handshake -> transmitted bits match 0x3C (0,0,1,1,1,1,0,0 LSB first).
REQ-031 Pulse valid during the DATA state -> no effect; only one frame is sent and no extra frame follows.
REQ-032 Assert rst_n=0 mid-DATA with clk stopped -> tx=1, ready=1, busy=0 immediately; a fresh 0x55 frame after release is correct.
REQ-033 CLKS_PER_BIT=1, send 0x81 -> 10-cycle frame 0,1,0,0,0,0,0,0,1,1.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART transmitter.
//   - state_t          : 2-bit FSM state encoding (IDLE, START, DATA, STOP)
//   - DEF_DATA_W       : default number of data bits per frame
//   - DEF_CLKS_PER_BIT : default clk cycles per serial bit
package uart_pkg;

   localparam int DEF_DATA_W       = 8;
   localparam int DEF_CLKS_PER_BIT = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } state_t;

endpackage

// File: rtl/uart_tx_if.sv
// uart_tx_if: word-level handshake between a producer and the UART transmitter.
//   data_in : parallel word to transmit (master -> slave)
//   valid   : data_in holds a word to send (master -> slave)
//   ready   : transmitter can accept a word this cycle (slave -> master)
interface uart_tx_if
   import uart_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W
) ();

   logic [DATA_W-1:0] data_in;
   logic              valid;
   logic              ready;

   modport master (output data_in, output valid, input ready);
   modport slave  (input data_in, input valid, output ready);

endinterface

// File: rtl/uart_tx_baud_gen.sv
// baud_gen: bit-period counter for the UART transmitter.
//   clk        : clock
//   rst_n      : asynchronous active-low reset
//   restart_i  : force the counter back to 0 (start of a new frame)
//   en_i       : count while a frame is in progress
//   bit_done_o : one-cycle pulse in the last cycle of each bit period
module baud_gen
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
   input  logic clk,
   input  logic rst_n,
   input  logic restart_i,
   input  logic en_i,
   output logic bit_done_o
);

   localparam int                 CNT_W = $clog2(CLKS_PER_BIT + 1);
   localparam logic [CNT_W-1:0]   LAST  = CNT_W'(CLKS_PER_BIT - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (restart_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // With CLKS_PER_BIT=1 the counter sits at 0 and this fires every enabled cycle.
   assign bit_done_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/uart_tx.sv
// uart_tx: serial transmitter, frame = start(0), DATA_W bits LSB first, stop(1).
//   clk   : clock
//   rst_n : asynchronous active-low reset; aborts any frame in flight
//   bus   : slave side of uart_tx_if (data_in, valid in; ready out)
//   tx    : serial line, idle high, straight from a flop
//   busy  : frame in progress (always the inverse of ready)
module uart_tx
   import uart_pkg::*;
#(
   parameter int DATA_W       = DEF_DATA_W,
   parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
   input  logic      clk,
   input  logic      rst_n,
   uart_tx_if.slave  bus,
   output logic      tx,
   output logic      busy
);

   localparam int               IDX_W    = $clog2(DATA_W + 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

   state_t            state_q;
   logic [DATA_W-1:0] shift_q;
   logic [IDX_W-1:0]  idx_q;
   logic              tx_q;
   logic              bit_done;
   logic              accept;

   assign bus.ready = (state_q == ST_IDLE);
   assign busy      = ~bus.ready;
   assign accept    = bus.valid && bus.ready;
   assign tx        = tx_q;

   // Restarting on accept aligns the first bit period to the accepting edge.
   baud_gen #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_baud_gen (
      .clk        (clk),
      .rst_n      (rst_n),
      .restart_i  (accept),
      .en_i       (busy),
      .bit_done_o (bit_done)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         shift_q <= '0;
         idx_q   <= '0;
         tx_q    <= 1'b1;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  // Start bit goes out on the accepting edge itself.
                  state_q <= ST_START;
                  shift_q <= bus.data_in;
                  idx_q   <= '0;
                  tx_q    <= 1'b0;
               end
            end
            ST_START: begin
               if (bit_done) begin
                  state_q <= ST_DATA;
                  tx_q    <= shift_q[0];
                  shift_q <= shift_q >> 1;
               end
            end
            ST_DATA: begin
               if (bit_done) begin
                  if (idx_q == LAST_IDX) begin
                     state_q <= ST_STOP;
                     tx_q    <= 1'b1;
                  end else begin
                     idx_q   <= idx_q + 1'b1;
                     tx_q    <= shift_q[0];
                     shift_q <= shift_q >> 1;
                  end
               end
            end
            ST_STOP: begin
               // Returning to IDLE guarantees at least one ready cycle between frames.
               if (bit_done) begin
                  state_q <= ST_IDLE;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               tx_q    <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: scoreboard bench for uart_tx with CLKS_PER_BIT=4 and =1.
module tb_uart_tx;

   localparam int DW    = 8;
   localparam int CPB_A = 4;
   localparam int CPB_B = 1;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   bit   clk_run = 1'b1;
   logic a_tx, a_busy, b_tx, b_busy;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int hs_cyc [2];

   logic [7:0] q0 [$];
   logic [7:0] q1 [$];

   int         mpos  [2] = '{-1, -1};
   logic [7:0] mword [2];
   int         merr  [2];
   logic [9:0] mobs  [2];

   uart_tx_if #(.DATA_W(DW)) a_if ();
   uart_tx_if #(.DATA_W(DW)) b_if ();

   uart_tx #(.DATA_W(DW), .CLKS_PER_BIT(CPB_A)) dut_a (
      .clk(clk), .rst_n(rst_n), .bus(a_if), .tx(a_tx), .busy(a_busy)
   );
   uart_tx #(.DATA_W(DW), .CLKS_PER_BIT(CPB_B)) dut_b (
      .clk(clk), .rst_n(rst_n), .bus(b_if), .tx(b_tx), .busy(b_busy)
   );

   always begin
      #5;
      if (clk_run) clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   // Reference frame: bit 0 start, bits 1..DW data LSB first, bit DW+1 stop.
   function automatic logic frame_bit(input logic [7:0] w, input int i);
      if (i == 0) return 1'b0;
      else if (i <= DW) return w[i-1];
      else return 1'b1;
   endfunction

   function automatic logic get_ready(input int idx);
      return (idx == 0) ? a_if.ready : b_if.ready;
   endfunction

   function automatic int qsize(input int idx);
      return (idx == 0) ? q0.size() : q1.size();
   endfunction

   task automatic drive(input int idx, input logic v, input logic [7:0] d);
      if (idx == 0) begin a_if.valid = v; a_if.data_in = d; end
      else begin b_if.valid = v; b_if.data_in = d; end
   endtask

   task automatic chk1(input string name, input logic got, input logic exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %b required %b", name, got, exp);
      end
   endtask

   task automatic chk_int(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d required %0d", name, got, exp);
      end
   endtask

   // Monitor: follows the line cycle by cycle, popping the expected word at each start bit.
   task automatic mon_step(input int idx, input logic txv, input logic rdy,
                           input logic bsy, input int cpb);
      int flen;
      logic [9:0] expv;
      flen = (DW + 2) * cpb;
      if (!rst_n) begin
         mpos[idx] = -1;
         if (idx == 0) q0.delete(); else q1.delete();
         return;
      end
      checks++;
      if (bsy !== ~rdy) begin
         errors++;
         $display("FAIL busy_vs_ready dut%0d cyc %0d: busy=%b ready=%b required busy=~ready",
                  idx, cyc, bsy, rdy);
      end
      if (mpos[idx] < 0 && txv === 1'b0) begin
         checks++;
         if (qsize(idx) == 0) begin
            errors++;
            $display("FAIL unexpected_frame dut%0d cyc %0d: start bit seen, required idle line",
                     idx, cyc);
            mword[idx] = 8'h00;
         end else begin
            mword[idx] = (idx == 0) ? q0.pop_front() : q1.pop_front();
         end
         mpos[idx] = 0;
         merr[idx] = 0;
         mobs[idx] = '0;
      end
      if (mpos[idx] >= 0 && mpos[idx] < flen) begin
         if (txv !== frame_bit(mword[idx], mpos[idx] / cpb) || rdy !== 1'b0) merr[idx]++;
         if (mpos[idx] % cpb == 0) mobs[idx][mpos[idx] / cpb] = txv;
         mpos[idx]++;
         if (mpos[idx] == flen) begin
            checks++;
            expv = {1'b1, mword[idx], 1'b0};
            if (merr[idx] != 0) begin
               errors++;
               $display("FAIL frame dut%0d word %02h: got bits %b required %b (%0d bad cycles)",
                        idx, mword[idx], mobs[idx], expv, merr[idx]);
            end else begin
               $display("frame dut%0d word %02h ok", idx, mword[idx]);
            end
         end
      end else if (mpos[idx] == flen) begin
         checks++;
         if (txv !== 1'b1 || rdy !== 1'b1) begin
            errors++;
            $display("FAIL idle_gap dut%0d: got tx=%b ready=%b required tx=1 ready=1",
                     idx, txv, rdy);
         end
         mpos[idx] = -1;
      end
   endtask

   always @(negedge clk or negedge rst_n) mon_step(0, a_tx, a_if.ready, a_busy, CPB_A);
   always @(negedge clk or negedge rst_n) mon_step(1, b_tx, b_if.ready, b_busy, CPB_B);

   // Present a word and wait (bounded) for the handshake; expected word is queued then.
   task automatic send(input int idx, input logic [7:0] w, input bit hold,
                       input logic [7:0] after);
      bit done;
      done = 1'b0;
      drive(idx, 1'b1, w);
      for (int i = 0; i < 400 && !done; i++) begin
         @(negedge clk);
         if (get_ready(idx)) begin
            if (idx == 0) q0.push_back(w); else q1.push_back(w);
            @(posedge clk);
            #1;
            hs_cyc[idx] = cyc;
            drive(idx, hold, after);
            done = 1'b1;
         end
      end
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL handshake_timeout dut%0d word %02h: got no ready required ready within 400 cycles",
                  idx, w);
         drive(idx, 1'b0, after);
      end
   endtask

   // A valid pulse while busy must be ignored.
   task automatic spur(input int idx);
      if (!get_ready(idx)) begin
         drive(idx, 1'b1, 8'($urandom));
         @(posedge clk);
         #1;
         drive(idx, 1'b0, 8'($urandom));
      end
   endtask

   task automatic wait_idle(input int idx);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 1000 && !ok; i++) begin
         @(negedge clk);
         if (qsize(idx) == 0 && mpos[idx] < 0 && get_ready(idx)) ok = 1'b1;
      end
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL drain dut%0d: got %0d frames pending required 0", idx, qsize(idx));
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got no finish required finish within 1 ms");
      $fatal(1, "watchdog");
   end

   initial begin
      int c1;
      logic [7:0] w;
      bit hold;
      drive(0, 1'b0, 8'h00);
      drive(1, 1'b0, 8'h00);
      repeat (3) @(posedge clk);
      #1;
      chk1("rst_tx_a", a_tx, 1'b1);
      chk1("rst_ready_a", a_if.ready, 1'b1);
      chk1("rst_busy_a", a_busy, 1'b0);
      chk1("rst_tx_b", b_tx, 1'b1);
      chk1("rst_busy_b", b_busy, 1'b0);

      // First handshake on the first posedge after release, frame 0xA5.
      @(negedge clk);
      drive(0, 1'b1, 8'hA5);
      q0.push_back(8'hA5);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk1("first_hs_tx", a_tx, 1'b0);
      chk1("first_hs_ready", a_if.ready, 1'b0);
      drive(0, 1'b0, 8'h5A);
      wait_idle(0);

      // Back-to-back with valid held: one idle cycle between frames.
      send(0, 8'h00, 1'b1, 8'hFF);
      c1 = hs_cyc[0];
      send(0, 8'hFF, 1'b0, 8'h12);
      chk_int("b2b_gap_a", hs_cyc[0] - c1, (DW + 2) * CPB_A + 1);
      wait_idle(0);

      // data_in changes right after the handshake.
      send(0, 8'h3C, 1'b0, 8'hC3);
      wait_idle(0);

      // valid pulse mid-DATA is ignored.
      send(0, 8'h5A, 1'b0, 8'h00);
      repeat (12) @(posedge clk);
      #1;
      spur(0);
      wait_idle(0);
      repeat (60) @(posedge clk);
      #1;
      chk1("no_extra_frame", a_busy, 1'b0);

      // Asynchronous reset mid-DATA with the clock stopped.
      send(0, 8'h96, 1'b0, 8'h00);
      repeat (16) @(posedge clk);
      @(negedge clk);
      clk_run = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk1("async_rst_tx", a_tx, 1'b1);
      chk1("async_rst_ready", a_if.ready, 1'b1);
      chk1("async_rst_busy", a_busy, 1'b0);
      #3 rst_n = 1'b1;
      drive(0, 1'b1, 8'h55);
      q0.push_back(8'h55);
      #2 clk_run = 1'b1;
      @(posedge clk);
      #1;
      chk1("post_rst_hs_tx", a_tx, 1'b0);
      drive(0, 1'b0, 8'hAA);
      wait_idle(0);

      // Randomized traffic on the CLKS_PER_BIT=4 instance.
      for (int n = 0; n < 25; n++) begin
         w = 8'($urandom);
         hold = ($urandom_range(0, 3) == 0);
         send(0, w, hold, 8'($urandom));
         if (!hold) begin
            if ($urandom_range(0, 1) == 1) begin
               repeat ($urandom_range(1, 30)) @(posedge clk);
               #1;
               spur(0);
            end
            repeat ($urandom_range(0, 50)) @(posedge clk);
            #1;
         end
      end
      drive(0, 1'b0, 8'h00);
      wait_idle(0);

      // CLKS_PER_BIT=1 instance.
      send(1, 8'h81, 1'b0, 8'h7E);
      wait_idle(1);
      send(1, 8'h00, 1'b1, 8'hFF);
      c1 = hs_cyc[1];
      send(1, 8'hFF, 1'b0, 8'h00);
      chk_int("b2b_gap_b", hs_cyc[1] - c1, (DW + 2) * CPB_B + 1);
      wait_idle(1);
      for (int n = 0; n < 12; n++) begin
         w = 8'($urandom);
         hold = ($urandom_range(0, 1) == 1);
         send(1, w, hold, 8'($urandom));
         if (!hold) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            spur(1);
         end
      end
      drive(1, 1'b0, 8'h00);
      wait_idle(1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
